// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the arbiter FSM state encodings.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

endpackage

// File: rtl/rr_picker.sv
// Request picker: round-robin from a completion-advanced pointer, or lowest index
// first when AXI_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_adv,
    input  logic [IDX_W-1:0] i_adv_idx,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_base;
    int               w_j;

`ifdef AXI_ARB_FIXED_PRIO_EN
    logic w_unused_ok;
    assign w_unused_ok = ^{i_clk, i_rst_n, i_adv, i_adv_idx};
    assign w_base      = '0;
`else
    logic [IDX_W-1:0] r_ptr;

    // The pointer moves past the owner only once its transaction has completed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (i_adv_idx == IDX_W'(N - 1)) ? '0 : i_adv_idx + 1'b1;
        end
    end

    assign w_base = r_ptr;
`endif

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(w_base) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/axi_nm_arbiter.sv
// N-master to 1-slave AXI4 arbiter with independent, burst-locked read and write channels.
// Define AXI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_nm_arbiter
    import axi_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_MASTERS-1:0]       i_m_arvalid,
    output logic [N_MASTERS-1:0]       o_m_arready,
    input  logic [N_MASTERS*ADDR_W-1:0] i_m_araddr,
    input  logic [N_MASTERS*ID_W-1:0]  i_m_arid,
    input  logic [N_MASTERS*8-1:0]     i_m_arlen,
    input  logic [N_MASTERS*3-1:0]     i_m_arsize,
    input  logic [N_MASTERS*2-1:0]     i_m_arburst,
    output logic [N_MASTERS-1:0]       o_m_rvalid,
    input  logic [N_MASTERS-1:0]       i_m_rready,
    output logic [DATA_W-1:0]          o_m_rdata,
    output logic [1:0]                 o_m_rresp,
    output logic                       o_m_rlast,
    output logic [ID_W-1:0]            o_m_rid,
    input  logic [N_MASTERS-1:0]       i_m_awvalid,
    output logic [N_MASTERS-1:0]       o_m_awready,
    input  logic [N_MASTERS*ADDR_W-1:0] i_m_awaddr,
    input  logic [N_MASTERS*ID_W-1:0]  i_m_awid,
    input  logic [N_MASTERS*8-1:0]     i_m_awlen,
    input  logic [N_MASTERS*3-1:0]     i_m_awsize,
    input  logic [N_MASTERS*2-1:0]     i_m_awburst,
    input  logic [N_MASTERS-1:0]       i_m_wvalid,
    output logic [N_MASTERS-1:0]       o_m_wready,
    input  logic [N_MASTERS*DATA_W-1:0] i_m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] i_m_wstrb,
    input  logic [N_MASTERS-1:0]       i_m_wlast,
    output logic [N_MASTERS-1:0]       o_m_bvalid,
    input  logic [N_MASTERS-1:0]       i_m_bready,
    output logic [1:0]                 o_m_bresp,
    output logic [ID_W-1:0]            o_m_bid,
    output logic                       o_s_awvalid,
    input  logic                       i_s_awready,
    output logic [ADDR_W-1:0]          o_s_awaddr,
    output logic [ID_W-1:0]            o_s_awid,
    output logic [7:0]                 o_s_awlen,
    output logic [2:0]                 o_s_awsize,
    output logic [1:0]                 o_s_awburst,
    output logic                       o_s_wvalid,
    input  logic                       i_s_wready,
    output logic [DATA_W-1:0]          o_s_wdata,
    output logic [DATA_W/8-1:0]        o_s_wstrb,
    output logic                       o_s_wlast,
    input  logic                       i_s_bvalid,
    output logic                       o_s_bready,
    input  logic [1:0]                 i_s_bresp,
    input  logic [ID_W-1:0]            i_s_bid,
    output logic                       o_s_arvalid,
    input  logic                       i_s_arready,
    output logic [ADDR_W-1:0]          o_s_araddr,
    output logic [ID_W-1:0]            o_s_arid,
    output logic [7:0]                 o_s_arlen,
    output logic [2:0]                 o_s_arsize,
    output logic [1:0]                 o_s_arburst,
    input  logic                       i_s_rvalid,
    output logic                       o_s_rready,
    input  logic [DATA_W-1:0]          i_s_rdata,
    input  logic [1:0]                 i_s_rresp,
    input  logic                       i_s_rlast,
    input  logic [ID_W-1:0]            i_s_rid
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int STRB_W = DATA_W / 8;

    rd_state_e        r_rstate;
    wr_state_e        r_wstate;
    logic [IDX_W-1:0] r_rgnt;
    logic [IDX_W-1:0] r_wgnt;
    logic             w_rany;
    logic             w_wany;
    logic [IDX_W-1:0] w_ridx;
    logic [IDX_W-1:0] w_widx;
    logic             w_rdone;
    logic             w_wdone;

    rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_rd_pick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_m_arvalid),
        .i_adv     (w_rdone),
        .i_adv_idx (r_rgnt),
        .o_any     (w_rany),
        .o_idx     (w_ridx)
    );

    rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_wr_pick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_m_awvalid),
        .i_adv     (w_wdone),
        .i_adv_idx (r_wgnt),
        .o_any     (w_wany),
        .o_idx     (w_widx)
    );

    assign w_rdone = (r_rstate == R_DATA) && i_s_rvalid && o_s_rready && i_s_rlast;
    assign w_wdone = (r_wstate == W_RESP) && i_s_bvalid && o_s_bready;

    // Grant is captured in IDLE and held until the last R beat / B response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rstate <= R_IDLE;
            r_rgnt   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_rany) begin
                    r_rgnt   <= w_ridx;
                    r_rstate <= R_ADDR;
                end
                R_ADDR:  if (o_s_arvalid && i_s_arready) r_rstate <= R_DATA;
                R_DATA:  if (w_rdone) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wstate <= W_IDLE;
            r_wgnt   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_wany) begin
                    r_wgnt   <= w_widx;
                    r_wstate <= W_ADDR;
                end
                W_ADDR:  if (o_s_awvalid && i_s_awready) r_wstate <= W_DATA;
                W_DATA:  if (o_s_wvalid && i_s_wready && o_s_wlast) r_wstate <= W_RESP;
                W_RESP:  if (w_wdone) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign o_s_arvalid = (r_rstate == R_ADDR) && i_m_arvalid[r_rgnt];
    assign o_s_araddr  = i_m_araddr[int'(r_rgnt)*ADDR_W +: ADDR_W];
    assign o_s_arid    = i_m_arid[int'(r_rgnt)*ID_W +: ID_W];
    assign o_s_arlen   = i_m_arlen[int'(r_rgnt)*8 +: 8];
    assign o_s_arsize  = i_m_arsize[int'(r_rgnt)*3 +: 3];
    assign o_s_arburst = i_m_arburst[int'(r_rgnt)*2 +: 2];
    assign o_s_rready  = (r_rstate == R_DATA) && i_m_rready[r_rgnt];

    assign o_m_rdata = i_s_rdata;
    assign o_m_rresp = i_s_rresp;
    assign o_m_rlast = i_s_rlast;
    assign o_m_rid   = i_s_rid;

    assign o_s_awvalid = (r_wstate == W_ADDR) && i_m_awvalid[r_wgnt];
    assign o_s_awaddr  = i_m_awaddr[int'(r_wgnt)*ADDR_W +: ADDR_W];
    assign o_s_awid    = i_m_awid[int'(r_wgnt)*ID_W +: ID_W];
    assign o_s_awlen   = i_m_awlen[int'(r_wgnt)*8 +: 8];
    assign o_s_awsize  = i_m_awsize[int'(r_wgnt)*3 +: 3];
    assign o_s_awburst = i_m_awburst[int'(r_wgnt)*2 +: 2];
    assign o_s_wvalid  = (r_wstate == W_DATA) && i_m_wvalid[r_wgnt];
    assign o_s_wdata   = i_m_wdata[int'(r_wgnt)*DATA_W +: DATA_W];
    assign o_s_wstrb   = i_m_wstrb[int'(r_wgnt)*STRB_W +: STRB_W];
    assign o_s_wlast   = i_m_wlast[r_wgnt];
    assign o_s_bready  = (r_wstate == W_RESP) && i_m_bready[r_wgnt];

    assign o_m_bresp = i_s_bresp;
    assign o_m_bid   = i_s_bid;

    // Only the owning master ever sees a ready or valid from the slave side.
    always_comb begin
        o_m_arready = '0;
        o_m_rvalid  = '0;
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bvalid  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_rgnt == IDX_W'(i)) begin
                o_m_arready[i] = (r_rstate == R_ADDR) && i_s_arready;
                o_m_rvalid[i]  = (r_rstate == R_DATA) && i_s_rvalid;
            end
            if (r_wgnt == IDX_W'(i)) begin
                o_m_awready[i] = (r_wstate == W_ADDR) && i_s_awready;
                o_m_wready[i]  = (r_wstate == W_DATA) && i_s_wready;
                o_m_bvalid[i]  = (r_wstate == W_RESP) && i_s_bvalid;
            end
        end
    end

endmodule

// File: tb/tb_axi_nm_arbiter.sv
// Directed self-checking bench for axi_nm_arbiter with two masters.
module tb_axi_nm_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0]   m_araddr, m_awaddr;
    logic [N*IW-1:0]   m_arid, m_awid;
    logic [N*8-1:0]    m_arlen, m_awlen;
    logic [N*3-1:0]    m_arsize, m_awsize;
    logic [N*2-1:0]    m_arburst, m_awburst;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp, m_bresp;
    logic              m_rlast;
    logic [IW-1:0]     m_rid, m_bid;
    logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [N*DW-1:0]   m_wdata;
    logic [N*DW/8-1:0] m_wstrb;

    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [IW-1:0]     s_awid, s_arid, s_bid, s_rid;
    logic [7:0]        s_awlen, s_arlen;
    logic [2:0]        s_awsize, s_arsize;
    logic [1:0]        s_awburst, s_arburst, s_bresp, s_rresp;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [DW/8-1:0]   s_wstrb;

    axi_nm_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_arvalid(m_arvalid), .o_m_arready(m_arready), .i_m_araddr(m_araddr),
        .i_m_arid(m_arid), .i_m_arlen(m_arlen), .i_m_arsize(m_arsize), .i_m_arburst(m_arburst),
        .o_m_rvalid(m_rvalid), .i_m_rready(m_rready), .o_m_rdata(m_rdata), .o_m_rresp(m_rresp),
        .o_m_rlast(m_rlast), .o_m_rid(m_rid),
        .i_m_awvalid(m_awvalid), .o_m_awready(m_awready), .i_m_awaddr(m_awaddr),
        .i_m_awid(m_awid), .i_m_awlen(m_awlen), .i_m_awsize(m_awsize), .i_m_awburst(m_awburst),
        .i_m_wvalid(m_wvalid), .o_m_wready(m_wready), .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb),
        .i_m_wlast(m_wlast), .o_m_bvalid(m_bvalid), .i_m_bready(m_bready), .o_m_bresp(m_bresp),
        .o_m_bid(m_bid),
        .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr), .o_s_awid(s_awid),
        .o_s_awlen(s_awlen), .o_s_awsize(s_awsize), .o_s_awburst(s_awburst),
        .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
        .o_s_wlast(s_wlast), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp),
        .i_s_bid(s_bid),
        .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr), .o_s_arid(s_arid),
        .o_s_arlen(s_arlen), .o_s_arsize(s_arsize), .o_s_arburst(s_arburst),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .i_s_rlast(s_rlast), .i_s_rid(s_rid)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] masterAddr(input int m);
        return (m == 1) ? 32'h8000_0000 : 32'h0000_1000;
    endfunction

    task automatic clearInputs();
        m_arvalid = '0; m_araddr = '0; m_arid = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
        m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_bready = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 0;
    endtask

    task automatic checkAllQuiet(input string tag);
        checkOutput(tag, {s_awvalid, s_wvalid, s_arvalid, s_rready, s_bready,
                          m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 64'd0);
    endtask

    // Full read burst: requesters in reqMask, expected owner expGnt, error response on beat errBeat.
    task automatic applyStimulus(input logic [1:0] reqMask, input int expGnt, input int beats,
                                 input int errBeat, input string tag);
        for (int i = 0; i < N; i++) begin
            if (reqMask[i]) begin
                m_arvalid[i]           = 1'b1;
                m_araddr[i*AW +: AW]   = masterAddr(i);
                m_arid[i*IW +: IW]     = IW'(i + 1);
                m_arlen[i*8 +: 8]      = 8'(beats - 1);
                m_arsize[i*3 +: 3]     = 3'd2;
                m_arburst[i*2 +: 2]    = 2'b01;
            end
        end
        s_arready = 1'b1;
        #1;
        checkOutput({tag, "_arb_cycle"}, s_arvalid, 0);
        tick();
        checkOutput({tag, "_arvalid"}, s_arvalid, 1);
        checkOutput({tag, "_araddr"}, s_araddr, masterAddr(expGnt));
        checkOutput({tag, "_arlen"}, s_arlen, beats - 1);
        checkOutput({tag, "_arready"}, m_arready, 64'(1) << expGnt);
        tick();
        m_arvalid[expGnt] = 1'b0;
        s_arready = 1'b0;
        m_rready  = 2'b11;
        for (int b = 0; b < beats; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'hA000_0000 + b;
            s_rresp  = (b == errBeat) ? 2'b10 : 2'b00;
            s_rlast  = (b == beats - 1);
            s_rid    = IW'(expGnt + 1);
            #1;
            checkOutput({tag, "_rvalid"}, m_rvalid, 64'(1) << expGnt);
            checkOutput({tag, "_rresp"}, m_rresp, (b == errBeat) ? 2'b10 : 2'b00);
            checkOutput({tag, "_rready"}, s_rready, 1);
            tick();
        end
        #1;
        checkOutput({tag, "_back_idle"}, {m_rvalid, s_rready}, 0);
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        m_rready = 2'b00;
    endtask

    initial begin
        int expGnt;
        clearInputs();
        rst_n = 1'b0;
        m_arvalid = 2'b11; m_awvalid = 2'b11; s_rvalid = 1; s_bvalid = 1; s_arready = 1;
        tick();
        tick();
        checkAllQuiet("reset_state");
        clearInputs();
        rst_n = 1'b1;
        tick();

        applyStimulus(2'b10, 1, 4, -1, "single_m1");
        checkOutput("single_m1_rdata_bcast", m_rdata, 32'hA000_0003);

        for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            expGnt = 0;
`else
            expGnt = k % 2;
`endif
            applyStimulus(2'b11, expGnt, 2, -1, $sformatf("contend%0d", k));
        end
        m_arvalid = 2'b00;
        tick();

        applyStimulus(2'b01, 0, 4, 1, "slverr");

        // Concurrent write by master 0 and read by master 1.
        m_awvalid = 2'b01; m_awaddr[0 +: AW] = 32'h2000_0000; m_awid[0 +: IW] = 4'h3;
        m_awlen[0 +: 8] = 8'd0; m_awsize[0 +: 3] = 3'd2; m_awburst[0 +: 2] = 2'b01;
        m_wvalid = 2'b01; m_wdata[0 +: DW] = 32'hDEAD_BEEF; m_wstrb[0 +: 4] = 4'hF; m_wlast = 2'b01;
        m_arvalid = 2'b10; m_araddr[AW +: AW] = 32'h8000_0000; m_arlen[8 +: 8] = 8'd0;
        s_awready = 1; s_wready = 1; s_arready = 1;
        #1;
        checkOutput("conc_arb_cycle", {s_awvalid, s_wvalid, s_arvalid}, 0);
        tick();
        checkOutput("conc_awaddr", s_awaddr, 32'h2000_0000);
        checkOutput("conc_w_blocked", {s_wvalid, m_wready}, 0);
        checkOutput("conc_readys", {m_awready, m_arready}, 4'b0110);
        tick();
        m_awvalid = 0; m_arvalid = 0; s_awready = 0; s_arready = 0;
        s_rvalid = 1; s_rlast = 1; s_rdata = 32'h0000_1234; m_rready = 2'b10;
        #1;
        checkOutput("conc_wdata", {s_wvalid, s_wdata, s_wstrb, s_wlast}, {1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1});
        checkOutput("conc_wready", m_wready, 2'b01);
        checkOutput("conc_rvalid", {m_rvalid, s_rready}, 3'b101);
        tick();
        m_wvalid = 0; m_wlast = 0; s_rvalid = 0; s_rlast = 0; m_rready = 0;
        s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'h3; m_bready = 2'b01;
        #1;
        checkOutput("conc_bvalid", m_bvalid, 2'b01);
        checkOutput("conc_bresp", {m_bresp, m_bid, s_bready}, {2'b00, 4'h3, 1'b1});
        tick();
        checkOutput("conc_b_done", m_bvalid, 0);
        clearInputs();
        tick();

        // Reset in the middle of an 8-beat write from master 0.
        m_awvalid = 2'b01; m_awaddr[0 +: AW] = 32'h3000_0000; m_awlen[0 +: 8] = 8'd7;
        s_awready = 1;
        tick();
        checkOutput("rst_awvalid", s_awvalid, 1);
        tick();
        m_awvalid = 0; s_awready = 0;
        m_wvalid = 2'b01; m_wdata[0 +: DW] = 32'h0000_0B00; s_wready = 1;
        #1;
        checkOutput("rst_beat1", s_wvalid, 1);
        tick();
        m_wdata[0 +: DW] = 32'h0000_0B01;
        #1;
        checkOutput("rst_beat2", s_wdata, 32'h0000_0B01);
        s_rvalid = 1; s_bvalid = 1; s_arready = 1; s_awready = 1;
        rst_n = 1'b0;
        #1;
        checkAllQuiet("rst_async");
        tick();
        checkAllQuiet("rst_edge");
        clearInputs();
        rst_n = 1'b1;
        tick();

        m_awvalid = 2'b10; m_awaddr[AW +: AW] = 32'h4000_0000; m_awid[IW +: IW] = 4'h9;
        s_awready = 1;
        #1;
        checkOutput("post_rst_arb_cycle", s_awvalid, 0);
        tick();
        checkOutput("post_rst_awaddr", {s_awvalid, s_awaddr, s_awid}, {1'b1, 32'h4000_0000, 4'h9});
        checkOutput("post_rst_awready", m_awready, 2'b10);
        tick();
        m_awvalid = 0; s_awready = 0;
        m_wvalid = 2'b10; m_wlast = 2'b10; m_wdata[DW +: DW] = 32'h5555_AAAA; s_wready = 1;
        #1;
        checkOutput("post_rst_wready", m_wready, 2'b10);
        tick();
        m_wvalid = 0; m_wlast = 0; s_wready = 0;
        s_bvalid = 1; m_bready = 2'b10;
        #1;
        checkOutput("post_rst_bvalid", m_bvalid, 2'b10);
        tick();
        clearInputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
